// File: rtl/nzcv_flag_gen.sv
// NZCV flag generator: S1 computes flags from an ALU result, S2 commits them to the architectural register.
// Optional macro NZCV_BYPASS_EN forwards in-flight flags combinationally and ties NZCV_VALID high.
module nzcv_flag_gen #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] RST_NZCV = 4'b0000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [1:0]       OP_CLASS,
  input  logic [WIDTH-1:0] RESULT,
  input  logic             ALU_C,
  input  logic             ALU_V,
  input  logic             SHIFT_C,
  input  logic             S_BIT,
  input  logic             COND_PASS,
  input  logic [3:0]       WR_NZCV,
  output logic [3:0]       NZCV,
  output logic             NZCV_VALID,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2
  } pend_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LOG = 2'b10;

  pend_e      state_q;
  logic       vld_p1_q, vld_p1_d;
  logic       vld_p2_q, vld_p2_d;
  logic [3:0] flags_p1_q, flags_p1_d;
  logic [3:0] flags_p2_q, flags_p2_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic       xfer, create, v_newest;
  logic [3:0] new_flags;

  function automatic logic [3:0] calc_flags(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] res,
    input logic             alu_c,
    input logic             alu_v,
    input logic             shift_c,
    input logic [3:0]       wr,
    input logic             v_keep
  );
    logic n, z;
    n = res[WIDTH-1];
    z = (res == '0);
    case (op)
      OP_ADD, OP_SUB: calc_flags = {n, z, alu_c, alu_v};
      OP_LOG:         calc_flags = {n, z, shift_c, v_keep};
      default:        calc_flags = wr;
    endcase
  endfunction

  assign IN_READY = ~STALL & ~FLUSH & ~RST;
  assign xfer     = IN_VALID & IN_READY;
  assign create   = xfer & S_BIT & COND_PASS;

  // Logical ops keep V from the youngest flag producer, whether pending or committed.
  assign v_newest  = vld_p1_q ? flags_p1_q[0] : (vld_p2_q ? flags_p2_q[0] : nzcv_q[0]);
  assign new_flags = calc_flags(OP_CLASS, RESULT, ALU_C, ALU_V, SHIFT_C, WR_NZCV, v_newest);

  always_comb begin
    vld_p1_d   = vld_p1_q;
    flags_p1_d = flags_p1_q;
    vld_p2_d   = 1'b0;
    flags_p2_d = flags_p1_q;
    nzcv_d     = nzcv_q;
    if (FLUSH) begin
      vld_p1_d = 1'b0;
    end else if (!STALL) begin
      vld_p1_d   = create;
      flags_p1_d = new_flags;
      vld_p2_d   = vld_p1_q;
    end
    if (vld_p2_q) nzcv_d = flags_p2_q;
  end

  // Stage p1/p2 boundary: control state with reset, payload registers free-running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      nzcv_q   <= RST_NZCV;
      state_q  <= IDLE;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      nzcv_q   <= nzcv_d;
      case ({vld_p1_d, vld_p2_d})
        2'b00:   state_q <= IDLE;
        2'b11:   state_q <= P2;
        default: state_q <= P1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    flags_p1_q <= flags_p1_d;
    flags_p2_q <= flags_p2_d;
  end

  assign BUSY = (state_q != IDLE);

`ifdef NZCV_BYPASS_EN
  assign NZCV       = vld_p1_q ? flags_p1_q : (vld_p2_q ? flags_p2_q : nzcv_q);
  assign NZCV_VALID = 1'b1;
`else
  assign NZCV       = nzcv_q;
  assign NZCV_VALID = ~BUSY;
`endif

endmodule

// File: tb/tb_nzcv_flag_gen.sv
// Directed bench for nzcv_flag_gen (WIDTH=32, default build without flag bypass).
module tb_nzcv_flag_gen;

  logic        CLK = 1'b0;
  logic        RST, IN_VALID, IN_READY, STALL, FLUSH;
  logic [1:0]  OP_CLASS;
  logic [31:0] RESULT;
  logic        ALU_C, ALU_V, SHIFT_C, S_BIT, COND_PASS;
  logic [3:0]  WR_NZCV, NZCV;
  logic        NZCV_VALID, BUSY;

  int checks = 0;
  int errors = 0;

  nzcv_flag_gen #(.WIDTH(32), .RST_NZCV(4'b0000)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .STALL(STALL), .FLUSH(FLUSH), .OP_CLASS(OP_CLASS), .RESULT(RESULT),
    .ALU_C(ALU_C), .ALU_V(ALU_V), .SHIFT_C(SHIFT_C), .S_BIT(S_BIT),
    .COND_PASS(COND_PASS), .WR_NZCV(WR_NZCV), .NZCV(NZCV),
    .NZCV_VALID(NZCV_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] nzcv, input logic busy, input logic nv);
    chk({tag, ".nzcv"}, {28'd0, NZCV}, {28'd0, nzcv});
    chk({tag, ".busy"}, {31'd0, BUSY}, {31'd0, busy});
    chk({tag, ".nzcv_valid"}, {31'd0, NZCV_VALID}, {31'd0, nv});
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] res,
                       input logic c, input logic ov, input logic sc, input logic s,
                       input logic cp, input logic [3:0] wr);
    IN_VALID = v; OP_CLASS = op; RESULT = res; ALU_C = c; ALU_V = ov;
    SHIFT_C = sc; S_BIT = s; COND_PASS = cp; WR_NZCV = wr;
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Reset held two cycles
    tick(); tick();
    chk_state("reset", 4'b0000, 1'b0, 1'b1);
    chk("reset.in_ready", {31'd0, IN_READY}, 32'd0);
    RST = 1'b0; #1;
    chk("post_reset.in_ready", {31'd0, IN_READY}, 32'd1);

    // Sub 5-5 -> Z and C set, two-cycle latency
    drive(1'b1, 2'b01, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    tick();
    IN_VALID = 1'b0;
    chk_state("sub.e1", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_state("sub.e2", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_state("sub.commit", 4'b0110, 1'b0, 1'b1);

    // Add with N,V then logical keeping V
    drive(1'b1, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    tick();
    drive(1'b1, 2'b10, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    tick();
    IN_VALID = 1'b0;
    chk_state("addlog.overlap", 4'b0110, 1'b1, 1'b0);
    tick();
    chk_state("addlog.add", 4'b1001, 1'b1, 1'b0);
    tick();
    chk_state("addlog.log", 4'b0011, 1'b0, 1'b1);

    // No flag effect when S_BIT or COND_PASS is low
    drive(1'b1, 2'b00, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    chk("nos.busy", {31'd0, BUSY}, 32'd0);
    S_BIT = 1'b1; COND_PASS = 1'b0;
    tick();
    chk("nocond.busy", {31'd0, BUSY}, 32'd0);
    IN_VALID = 1'b0;
    tick(); tick();
    chk_state("noflag.hold", 4'b0011, 1'b0, 1'b1);

    // Flush kills S1 and drops the new op; the older S2 op still commits
    drive(1'b1, 2'b00, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    tick();
    drive(1'b1, 2'b01, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    tick();
    chk("flush.busy_pre", {31'd0, BUSY}, 32'd1);
    drive(1'b1, 2'b11, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    FLUSH = 1'b1; #1;
    chk("flush.in_ready", {31'd0, IN_READY}, 32'd0);
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk_state("flush.s2_commit", 4'b1010, 1'b0, 1'b1);
    tick(); tick();
    chk_state("flush.after", 4'b1010, 1'b0, 1'b1);

    // Direct write held by three stall cycles
    drive(1'b1, 2'b11, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101);
    tick();
    IN_VALID = 1'b0; STALL = 1'b1; #1;
    chk("stall.in_ready", {31'd0, IN_READY}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("stall.hold", 4'b1010, 1'b1, 1'b0);
    end
    STALL = 1'b0;
    tick();
    chk_state("stall.s2", 4'b1010, 1'b1, 1'b0);
    tick();
    chk_state("stall.commit", 4'b0101, 1'b0, 1'b1);

    // Flush together with stall clears S1
    drive(1'b1, 2'b00, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    tick();
    IN_VALID = 1'b0; STALL = 1'b1; FLUSH = 1'b1;
    tick();
    STALL = 1'b0; FLUSH = 1'b0;
    chk("flushstall.busy", {31'd0, BUSY}, 32'd0);
    tick(); tick();
    chk_state("flushstall.hold", 4'b0101, 1'b0, 1'b1);

    // Reset mid-flight discards pending flags
    drive(1'b1, 2'b11, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    tick();
    IN_VALID = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_state("midreset", 4'b0000, 1'b0, 1'b1);
    tick(); tick();
    chk_state("midreset.after", 4'b0000, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
